// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   XLEN             - datapath / address width.
//   DEFAULT_RESET_PC - default PC loaded on reset.
//   DEFAULT_NOP_INST - instruction driven to the decoder when nothing is held
//                      (ADDI x0,x0,0).
//   fetch_state_e    - fetch FSM state encoding.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,   // request outstanding for pc
        ST_HOLD  = 2'd1,   // instruction held, waiting for inst_ready
        ST_DROP  = 2'd2,   // stale request outstanding, result will be discarded
        ST_FAULT = 2'd3    // misaligned redirect seen, waiting for aligned redirect
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's handshake signals.
//   imem_*      - word read channel to instruction memory (req/ack).
//   inst*       - instruction register toward the decoder (valid/ready).
//   redirect_*  - PC redirect from jump control.
//   misaligned_fault - sticky fault flag from the fetch stage.
// Modports:
//   master - the fetch unit side.
//   slave  - the environment (memory, decoder, jump control).
interface fetch_unit_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_valid;
    logic            inst_ready;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            misaligned_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst, inst_pc, inst_valid,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output misaligned_fault
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst, inst_pc, inst_valid,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  misaligned_fault
    );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage upstream of the decoder.
// Owns the PC, issues one word read at a time to instruction memory and
// holds the returned word in an instruction register until the decoder
// takes it. No prefetch: one bubble cycle per instruction.
// Ports:
//   clk   - rising-edge clock.
//   reset - synchronous, active-high reset.
//   bus   - fetch_unit_if.master (imem channel, inst register, redirect,
//           misaligned_fault).
// Parameters:
//   RESET_PC - PC loaded on reset.
//   NOP_INST - value on inst when no valid instruction is held.
//
// state | meaning
// REQ   | read of pc outstanding; ack latches the word and moves to HOLD
// HOLD  | word held on inst, waits for inst_ready
// DROP  | read of an old address outstanding; its ack is discarded
// FAULT | misaligned redirect seen; only an aligned redirect leaves
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;

    logic            ack_live;
    logic            redir_misaligned;

    // An ack only counts while a request is actually on the bus.
    assign ack_live         = bus.imem_ack & req_q;
    assign redir_misaligned = (bus.redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        fault_d   = fault_q;

        if (bus.redirect_valid) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            if (redir_misaligned) begin
                fault_d = 1'b1;
                state_d = ST_FAULT;
            end else begin
                fault_d = 1'b0;
                pc_d    = bus.redirect_pc;
                case (state_q)
                    // Without an ack the old read is still in flight and must
                    // be drained before the new address can go out.
                    ST_REQ:   state_d = ack_live ? ST_REQ : ST_DROP;
                    ST_DROP:  state_d = ack_live ? ST_REQ : ST_DROP;
                    ST_HOLD:  state_d = ST_REQ;
                    ST_FAULT: state_d = ST_REQ;
                    default:  state_d = ST_REQ;
                endcase
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (ack_live) begin
                        inst_d    = bus.imem_rdata;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.inst_ready) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (ack_live) begin
                        state_d = ST_REQ;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end

        // A fresh request always targets the current pc; in DROP the bus
        // keeps the stale address until its ack arrives.
        req_d  = (state_d == ST_REQ) || (state_d == ST_DROP);
        addr_d = (state_d == ST_REQ) ? pc_d : addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b1;
            inst_q    <= NOP_INST;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.imem_req         = req_q;
    assign bus.imem_addr        = addr_q;
    assign bus.inst             = inst_q;
    assign bus.inst_pc          = inst_pc_q;
    assign bus.inst_valid       = valid_q;
    assign bus.misaligned_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected
// (inst, inst_pc) pairs; a monitor pops one entry each time a new
// instruction appears on the decoder side.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic reset;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares each newly presented instruction with the scoreboard.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (bus.inst_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got inst %h pc %h expected none",
                             bus.inst, bus.inst_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_inst", bus.inst, e.inst);
                    check("sb_inst_pc", bus.inst_pc, e.pc);
                end
            end
            if (!bus.inst_valid) check("idle_inst_nop", bus.inst, NOP);
            prev_valid <= bus.inst_valid;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ack(input logic [31:0] data);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    task automatic consume();
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] data, input logic [31:0] pc);
        exp_t e;
        check("fetch_req", {31'd0, bus.imem_req}, 32'd1);
        check("fetch_addr", bus.imem_addr, pc);
        e.inst = data;
        e.pc   = pc;
        exp_q.push_back(e);
        ack(data);
        check("fetch_valid", {31'd0, bus.inst_valid}, 32'd1);
        consume();
    endtask

    initial begin
        reset              = 1'b1;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) tick();

        // Reset state
        check("rst_req", {31'd0, bus.imem_req}, 32'd1);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_inst", bus.inst, NOP);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_fault", {31'd0, bus.misaligned_fault}, 32'd0);
        reset = 1'b0;

        // First fetch, ack two cycles later
        repeat (2) tick();
        check("t1_req", {31'd0, bus.imem_req}, 32'd1);
        check("t1_addr", bus.imem_addr, 32'h0);
        exp_q.push_back('{inst: 32'h0050_0093, pc: 32'h0});
        ack(32'h0050_0093);
        check("t1_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("t1_req_hold", {31'd0, bus.imem_req}, 32'd0);

        // Backpressure for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_inst", bus.inst, 32'h0050_0093);
            check("t2_inst_pc", bus.inst_pc, 32'h0);
            check("t2_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("t2_req", {31'd0, bus.imem_req}, 32'd0);
        end
        consume();
        check("t2_next_req", {31'd0, bus.imem_req}, 32'd1);
        check("t2_next_addr", bus.imem_addr, 32'h4);
        check("t2_valid_clr", {31'd0, bus.inst_valid}, 32'd0);

        // inst_ready with nothing valid changes nothing
        consume();
        check("rdy_idle_addr", bus.imem_addr, 32'h4);
        check("rdy_idle_req", {31'd0, bus.imem_req}, 32'd1);

        // Redirect in REQ without ack: stale read drained, data dropped
        redirect(32'h100);
        check("t3_drop_req", {31'd0, bus.imem_req}, 32'd1);
        check("t3_drop_addr", bus.imem_addr, 32'h4);
        tick();
        check("t3_drop_addr2", bus.imem_addr, 32'h4);
        ack(32'hDEAD_BEEF);
        check("t3_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("t3_inst", bus.inst, NOP);
        fetch(32'h00A0_0113, 32'h100);

        // Redirect and ack in the same cycle
        check("t4_addr_before", bus.imem_addr, 32'h104);
        bus.imem_ack       = 1'b1;
        bus.imem_rdata     = 32'h2222_2222;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        tick();
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        check("t4_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("t4_req", {31'd0, bus.imem_req}, 32'd1);
        check("t4_addr", bus.imem_addr, 32'h40);
        fetch(32'h0000_0033, 32'h40);

        // Misaligned redirect, stray ack ignored, aligned redirect recovers
        redirect(32'h102);
        check("t5_fault", {31'd0, bus.misaligned_fault}, 32'd1);
        check("t5_req", {31'd0, bus.imem_req}, 32'd0);
        check("t5_valid", {31'd0, bus.inst_valid}, 32'd0);
        ack(32'h5555_5555);
        repeat (2) tick();
        check("t5_fault_sticky", {31'd0, bus.misaligned_fault}, 32'd1);
        check("t5_req_off", {31'd0, bus.imem_req}, 32'd0);
        check("t5_valid_off", {31'd0, bus.inst_valid}, 32'd0);
        redirect(32'h200);
        check("t5_fault_clr", {31'd0, bus.misaligned_fault}, 32'd0);
        check("t5_req_on", {31'd0, bus.imem_req}, 32'd1);
        check("t5_addr", bus.imem_addr, 32'h200);
        fetch(32'h0010_0093, 32'h200);

        // Get to pc=8 via a drained redirect, then reset mid-request
        redirect(32'h8);
        ack(32'hDEAD_BEEF);
        check("t6_addr_pre", bus.imem_addr, 32'h8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_addr", bus.imem_addr, 32'h0);
        check("t6_req", {31'd0, bus.imem_req}, 32'd1);
        check("t6_inst", bus.inst, NOP);
        check("t6_valid", {31'd0, bus.inst_valid}, 32'd0);
        // Late ack after reset is taken as the RESET_PC fetch
        fetch(32'h0030_0193, 32'h0);

        // PC wraps past the top of the address space
        redirect(32'hFFFF_FFFC);
        ack(32'hDEAD_BEEF);
        fetch(32'h0040_0213, 32'hFFFF_FFFC);
        check("wrap_addr", bus.imem_addr, 32'h0);
        check("wrap_req", {31'd0, bus.imem_req}, 32'd1);

        repeat (2) tick();
        check("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Owns the program counter and issues word reads to instruction memory over a req/ack handshake. Latches the returned word into an instruction register that drives the decoder's inst input, with a valid/ready pair toward the stage that consumes it. Accepts PC redirects from jump control and discards stale in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, value driven on inst when no valid instruction is held (ADDI x0,x0,0).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  reset, synchronous, active-high.
imem_req  out  1  read request to instruction memory; level, held until imem_ack.
imem_addr  out  32  word address of the request; stable while imem_req=1.
imem_ack  in  1  single-cycle pulse; imem_rdata is valid in the same cycle.
imem_rdata  in  32  fetched instruction word.
inst  out  32  instruction register, feeds the decoder.
inst_pc  out  32  PC of the instruction held in inst.
inst_valid  out  1  inst/inst_pc hold a valid instruction.
inst_ready  in  1  downstream accepts inst this cycle when inst_valid=1.
redirect_valid  in  1  jump/branch taken; load redirect_pc.
redirect_pc  in  32  new fetch target.
misaligned_fault  out  1  sticky; redirect target not 4-byte aligned.

Behaviour:
- Reset (synchronous, priority over all inputs): pc=RESET_PC, state=REQ, inst=NOP_INST, inst_pc=0, inst_valid=0, misaligned_fault=0. imem_req is 1 in the first cycle after reset deasserts, with imem_addr=RESET_PC. A reset arriving mid-request abandons that request; a late imem_ack arriving after reset is ignored unless the unit is in REQ, where it is accepted as the RESET_PC fetch.
- States: REQ, HOLD, DROP, FAULT.
- REQ: imem_req=1, imem_addr=pc. On imem_ack, latch inst=imem_rdata and inst_pc=pc, set inst_valid=1, set pc=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 wraps to 0), and go to HOLD. Latency is 1 cycle from ack to inst_valid.
- HOLD: imem_req=0; inst is held stable. When inst_ready=1, set inst_valid=0 and inst=NOP_INST, and go to REQ. This gives one bubble cycle per instruction; no prefetch.
- DROP: a request is outstanding whose result is stale. imem_req stays 1 with the old address. On imem_ack, discard the data and go to REQ at the new pc.
- Redirect (redirect_valid=1) has priority over ack and ready in every state:
  - If redirect_pc[1:0]!=0: set misaligned_fault=1, set inst_valid=0, go to FAULT.
  - Otherwise: set pc=redirect_pc, set inst_valid=0, set inst=NOP_INST.
    - From REQ without a same-cycle ack: go to DROP.
    - From REQ with a same-cycle ack: discard rdata and go to REQ.
    - From HOLD or DROP: go to REQ, except that DROP without an ack stays in DROP.
- FAULT: imem_req=0, inst_valid=0. An aligned redirect clears misaligned_fault and goes to REQ. Only that, or reset, exits FAULT.
- imem_ack while imem_req=0 is ignored.
- inst_ready while inst_valid=0 has no effect.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (REQ, HOLD, DROP, FAULT);
  - NOP_INST and default RESET_PC constants;
  - XLEN=32 localparam.
- No sub-module: the PC incrementer and next-state logic stay inline in a single module.

Test Plan:
- Reset, then ack after 2 cycles with rdata=32'h00500093 -> imem_addr=0; one cycle after ack, inst=32'h00500093, inst_pc=0, inst_valid=1; after inst_ready, next imem_addr=4.
- Hold inst_ready=0 for 5 cycles while valid -> inst, inst_pc and inst_valid stay stable and imem_req=0; assert ready -> fetch of pc+4 starts the next cycle.
- redirect_pc=32'h100 while in REQ with no ack -> DROP; the following ack with rdata=32'hDEADBEEF is discarded; next request has imem_addr=32'h100 and inst never shows DEADBEEF.
- redirect_valid and imem_ack in the same cycle (redirect_pc=32'h40) -> rdata discarded, inst_valid stays 0, next imem_addr=32'h40.
- redirect_pc=32'h102 -> misaligned_fault=1, imem_req=0 thereafter; then redirect_pc=32'h200 -> fault clears and imem_addr=32'h200.
- Reset asserted mid-request at pc=32'h8 -> next cycle imem_addr=RESET_PC, inst=NOP_INST, inst_valid=0.
